// File: rtl/nmem_update_sched_pkg.sv
// Shared widths, FSM encoding and operand-forward selects for the node-memory update scheduler.
// Optional forwarding is enabled by defining NMEM_UPDATE_FWD_EN.
package nmem_update_sched_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Source of the stage-B operand: memory, live write-stage sum, or value captured at accept.
    typedef enum logic [1:0] {
        FWD_MEM = 2'd0,
        FWD_SUM = 2'd1,
        FWD_CAP = 2'd2
    } fwd_sel_t;

endpackage

// File: rtl/nmem_update_sched_hazard.sv
// Address compares against in-flight stages; produces a stall or, with NMEM_UPDATE_FWD_EN
// defined, an operand-forward select instead.
module nmem_hazard_unit
    import nmem_update_sched_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic              w_valid,
    input  logic [ADDR_W-1:0] w_addr,
    output logic              stall,
    output fwd_sel_t          fwd_sel
);

    logic hit_b;
    logic hit_w;

    assign hit_b = b_valid && (in_addr == b_addr);
    assign hit_w = w_valid && (in_addr == w_addr);

`ifdef NMEM_UPDATE_FWD_EN
    assign stall = 1'b0;

    // A stage-B match is the newest value, so it wins over a write-stage match.
    always_comb begin
        fwd_sel = FWD_MEM;
        if (hit_b) begin
            fwd_sel = FWD_SUM;
        end else if (hit_w) begin
            fwd_sel = FWD_CAP;
        end
    end
`else
    assign stall   = hit_b || hit_w;
    assign fwd_sel = FWD_MEM;
`endif

endmodule

// File: rtl/nmem_update_sched.sv
// Read-modify-write scheduler for PE node-state memory: accept, read+add, write back, count commits.
// Define NMEM_UPDATE_FWD_EN to forward in-flight sums instead of stalling on address hazards.
module nmem_update_sched
    import nmem_update_sched_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  expected_cnt,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic [ADDR_W-1:0] mem_rdaddr,
    input  logic [DATA_W-1:0] mem_q,
    output logic [ADDR_W-1:0] mem_wraddr,
    output logic [DATA_W-1:0] mem_wrdata,
    output logic              mem_wren,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  commit_cnt
);

    state_t            state;
    logic [CNT_W-1:0]  expected_q;
    logic [CNT_W-1:0]  accepted_cnt;
    logic [CNT_W-1:0]  acc_next;

    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    fwd_sel_t          b_src;
    logic [DATA_W-1:0] b_cap;

    logic              stall;
    fwd_sel_t          fwd_sel;
    logic              accept;
    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] sum;

    nmem_hazard_unit #(
        .ADDR_W(ADDR_W)
    ) u_hazard (
        .in_addr (in_addr),
        .b_valid (b_valid),
        .b_addr  (b_addr),
        .w_valid (mem_wren),
        .w_addr  (mem_wraddr),
        .stall   (stall),
        .fwd_sel (fwd_sel)
    );

    assign mem_rdaddr = in_addr;
    assign in_ready   = (state == ST_RUN) && !stall && (accepted_cnt < expected_q);
    assign accept     = in_valid && in_ready;
    assign acc_next   = accept ? accepted_cnt + CNT_W'(1) : accepted_cnt;

    always_comb begin
        operand = mem_q;
        case (b_src)
            FWD_SUM: operand = mem_wrdata;
            FWD_CAP: operand = b_cap;
            default: operand = mem_q;
        endcase
    end

    assign sum = operand + b_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            expected_q   <= '0;
            accepted_cnt <= '0;
            commit_cnt   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            b_valid      <= 1'b0;
            b_addr       <= '0;
            b_data       <= '0;
            b_src        <= FWD_MEM;
            b_cap        <= '0;
            mem_wren     <= 1'b0;
            mem_wraddr   <= '0;
            mem_wrdata   <= '0;
        end else begin
            done <= 1'b0;

            b_valid <= accept;
            if (accept) begin
                b_addr       <= in_addr;
                b_data       <= in_data;
                b_src        <= fwd_sel;
                b_cap        <= mem_wrdata;
                accepted_cnt <= acc_next;
            end

            mem_wren <= b_valid;
            if (b_valid) begin
                mem_wraddr <= b_addr;
                mem_wrdata <= sum;
            end

            if (mem_wren) begin
                commit_cnt <= commit_cnt + CNT_W'(1);
            end

            // DRAIN ends once B is empty: the write stage empties on that same edge.
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        expected_q   <= expected_cnt;
                        accepted_cnt <= '0;
                        commit_cnt   <= '0;
                        if (expected_cnt == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (acc_next == expected_q) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!b_valid) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nmem_update_sched.sv
// Scoreboard bench for nmem_update_sched: expected writes are queued at accept, a monitor
// pops them on every mem_wren. Honours NMEM_UPDATE_FWD_EN for the hazard-stall expectation.
module tb_nmem_update_sched;
    import nmem_update_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] expected_cnt = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [9:0]  in_addr = '0;
    logic [31:0] in_data = '0;
    logic [9:0]  mem_rdaddr;
    logic [31:0] mem_q = '0;
    logic [9:0]  mem_wraddr;
    logic [31:0] mem_wrdata;
    logic        mem_wren;
    logic        busy;
    logic        done;
    logic [15:0] commit_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_count = 0;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t sb[$];

    logic [31:0] mem [0:1023] = '{default: '0};
    logic        poke_en = 1'b0;
    logic [9:0]  poke_addr = '0;
    logic [31:0] poke_data = '0;

    always #5 clk = ~clk;

    nmem_update_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .expected_cnt (expected_cnt),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_addr      (in_addr),
        .in_data      (in_data),
        .mem_rdaddr   (mem_rdaddr),
        .mem_q        (mem_q),
        .mem_wraddr   (mem_wraddr),
        .mem_wrdata   (mem_wrdata),
        .mem_wren     (mem_wren),
        .busy         (busy),
        .done         (done),
        .commit_cnt   (commit_cnt)
    );

    // Node memory: 1-cycle read latency, read-old-data on same-address write.
    always @(posedge clk) begin
        mem_q <= mem[mem_rdaddr];
        if (mem_wren) mem[mem_wraddr] <= mem_wrdata;
        if (poke_en)  mem[poke_addr]  <= poke_data;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_wren) begin
            wr_count++;
            if (sb.size() == 0) begin
                chk("unexpected_write", 64'(mem_wraddr), 64'h3ff_dead);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", 64'(mem_wraddr), 64'(e.addr));
                chk("wr_data", 64'(mem_wrdata), 64'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [9:0] a, input logic [31:0] d);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        tick();
        poke_en = 1'b0;
    endtask

    task automatic do_start(input logic [15:0] n);
        expected_cnt = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Holds the request until accepted; exp_wr is the hand-computed write-back value.
    task automatic send(input logic [9:0] a, input logic [31:0] d, input logic [31:0] exp_wr,
                        output int stalls);
        bit ok;
        in_valid = 1'b1; in_addr = a; in_data = d;
        stalls = 0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            stalls++;
        end
        if (!ok) begin
            chk("accept_timeout", 64'(stalls), 64'd0);
        end else begin
            sb.push_back('{addr: a, data: exp_wr});
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            cycles++;
            if (done) return;
        end
        chk("done_timeout", 64'(cycles), 64'd0);
    endtask

    initial begin
        int st;
        int cyc;
        int wr0;
        int rdy_seen;
        int done_seen;

        repeat (3) tick();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_wren", 64'(mem_wren), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_commit", 64'(commit_cnt), 64'd0);
        chk("rst_wraddr", 64'(mem_wraddr), 64'd0);
        chk("rst_wrdata", 64'(mem_wrdata), 64'd0);
        rst_n = 1'b1;
        tick();

        // Back-to-back updates to distinct addresses.
        do_start(16'd3);
        chk("run_busy", 64'(busy), 64'd1);
        send(10'd5, 32'd1, 32'd1, st); chk("b2b_stall0", 64'(st), 64'd0);
        send(10'd6, 32'd2, 32'd2, st); chk("b2b_stall1", 64'(st), 64'd0);
        send(10'd7, 32'd3, 32'd3, st); chk("b2b_stall2", 64'(st), 64'd0);
        wait_done(cyc);
        chk("b2b_done_lat", 64'(cyc), 64'd2);
        chk("b2b_commit", 64'(commit_cnt), 64'd3);
        tick();
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("mem5", 64'(mem[5]), 64'd1);
        chk("mem6", 64'(mem[6]), 64'd2);
        chk("mem7", 64'(mem[7]), 64'd3);

        // Same-address updates back to back.
        poke(10'd4, 32'd10);
        do_start(16'd2);
        send(10'd4, 32'd1, 32'd11, st); chk("haz_stall0", 64'(st), 64'd0);
        send(10'd4, 32'd1, 32'd12, st);
`ifdef NMEM_UPDATE_FWD_EN
        chk("haz_stall1", 64'(st), 64'd0);
`else
        chk("haz_stall1", 64'(st), 64'd2);
`endif
        wait_done(cyc);
        tick();
        chk("mem4", 64'(mem[4]), 64'd12);
        chk("haz_commit", 64'(commit_cnt), 64'd2);

        // Empty pass.
        wr0 = wr_count;
        do_start(16'd0);
        chk("zero_done", 64'(done), 64'd1);
        tick();
        chk("zero_done_drop", 64'(done), 64'd0);
        chk("zero_no_write", 64'(wr_count - wr0), 64'd0);

        // Carry dropped on wrap.
        poke(10'd9, 32'hFFFF_FFFF);
        do_start(16'd1);
        send(10'd9, 32'd2, 32'd1, st);
        wait_done(cyc);
        tick();
        chk("mem9_wrap", 64'(mem[9]), 64'd1);

        // Reset while an update sits in stage B.
        wr0 = wr_count;
        do_start(16'd2);
        send(10'd3, 32'd5, 32'd5, st);
        rst_n = 1'b0;
        tick();
        sb.delete();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("rst_mid_no_write", 64'(wr_count - wr0), 64'd0);
        chk("rst_mid_mem3", 64'(mem[3]), 64'd0);
        chk("rst_mid_state", 64'(dut.state), 64'(ST_IDLE));
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_commit", 64'(commit_cnt), 64'd0);

        // Request beyond the expected count is not consumed.
        do_start(16'd2);
        send(10'd20, 32'd1, 32'd1, st);
        send(10'd21, 32'd7, 32'd7, st);
        in_valid = 1'b1; in_addr = 10'd22; in_data = 32'd9;
        rdy_seen = 0;
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (in_ready) rdy_seen++;
            if (done) begin
                done_seen++;
                chk("extra_commit", 64'(commit_cnt), 64'd2);
            end
        end
        in_valid = 1'b0;
        tick();
        chk("extra_ready", 64'(rdy_seen), 64'd0);
        chk("extra_done", 64'(done_seen), 64'd1);
        chk("mem22", 64'(mem[22]), 64'd0);
        chk("mem21", 64'(mem[21]), 64'd7);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
